fence_display_sequencer: RTL and testbench
==========================================

Name: fence_display_sequencer

Overview:
- Game-level controller that sequences the pixel display mux for the fencing game: start screen, countdown, live play, hit flash and round-over.
- Drives the mux's layer selects (start screen, border, boxes, sabers) and keeps the score.
- Sits in the pixel clock domain between hit detection / frame timing and the display mux.
- All outputs are registered.

Parameters:
- FRAMES_PER_SEC, 60, new_frame_in pulses per countdown second.
- COUNTDOWN_SEC, 3, countdown length in seconds; must be ≥1 and <16.
- FLASH_FRAMES, 30, frames of border flash/freeze after a scoring hit.
- WIN_SCORE, 5, points needed to end the round.
- SCORE_W, 4, score counter width; WIN_SCORE < 2^SCORE_W.

Ports:
- clk_in  input  1  pixel clock.
- rst_n_in  input  1  asynchronous active-low reset.
- new_frame_in  input  1  one-cycle pulse at start of each frame.
- start_btn_in  input  1  synchronized, debounced level; rising edge detected internally.
- player_hit_in  input  1  one-cycle pulse: player landed a hit.
- opponent_hit_in  input  1  one-cycle pulse: opponent landed a hit.
- start_display_out  output  1  select start-screen layer.
- border_en_out  output  1  force border layer (white).
- saber_en_out  output  1  enable saber layers.
- box_en_out  output  1  enable player/opponent box layers.
- countdown_out  output  4  current countdown digit, 0 outside COUNTDOWN.
- player_score_out  output  SCORE_W  player points.
- opponent_score_out  output  SCORE_W  opponent points.
- winner_out  output  2  00 none, 01 player, 10 opponent, 11 draw.
- state_out  output  3  current state encoding, for debug.

Behaviour:
- Reset, asserted asynchronously at any time including mid-round:
  - State goes to IDLE.
  - Scores, counters, winner_out and countdown_out go to 0.
  - start_display_out = 1; all other enables = 0.
- States and encodings: IDLE=0, COUNTDOWN=1, PLAY=2, HIT_FLASH=3, ROUND_OVER=4.
- Start edge: start_btn_in high this cycle and low the previous cycle. The edge register resets to 1, so a button held through reset does not produce an edge.
- IDLE:
  - Outputs: start_display=1, others 0.
  - On start edge: clear scores and winner, countdown_out = COUNTDOWN_SEC, frame counter = 0, go to COUNTDOWN.
- COUNTDOWN:
  - Outputs: box_en=1, start_display=0, saber_en=0.
  - Each new_frame_in increments the frame counter. When it reaches FRAMES_PER_SEC-1 and a new_frame_in arrives, the counter wraps to 0 and countdown_out decrements.
  - The decrement that takes countdown_out to 0 moves the FSM to PLAY on the same clock edge.
- PLAY:
  - Outputs: box_en=1, saber_en=1.
  - player_hit only: player_score +1.
  - opponent_hit only: opponent_score +1.
  - Both in the same cycle (double touch): both scores +1.
  - After any hit, if either updated score ≥ WIN_SCORE, go to ROUND_OVER and set winner_out: 01 player, 10 opponent, 11 if both reached it in the same cycle. Otherwise go to HIT_FLASH with the flash counter = 0.
  - Scores saturate at 2^SCORE_W-1.
- HIT_FLASH:
  - Outputs: border_en = 1 on even frame counts and 0 on odd (toggles each new_frame_in); box_en=1; saber_en=0.
  - Hits are ignored.
  - After FLASH_FRAMES new_frame_in pulses: reload countdown_out = COUNTDOWN_SEC, go to COUNTDOWN.
- ROUND_OVER:
  - Outputs: border_en=1, box_en=1, scores and winner held.
  - On start edge: go to IDLE with scores and winner kept visible. They clear on the next IDLE start edge.
- Hit pulses outside PLAY are dropped, not queued.
- start_btn_in is ignored in COUNTDOWN, PLAY and HIT_FLASH.
- Latency: every transition and output update is visible one clk_in edge after the qualifying input cycle.
- new_frame_in coinciding with a hit in PLAY: the hit is processed; the frame pulse has no effect in PLAY.

Test Plan:
- Reset then idle:
  - Stimulus: rst_n_in low mid-cycle, release, no start.
  - Required: state_out=0, start_display_out=1, scores 0, winner 00; holds indefinitely.
- Countdown timing, FRAMES_PER_SEC=4, COUNTDOWN_SEC=3:
  - Stimulus: start edge, then 12 frame pulses.
  - Required: countdown_out 3→2 after 4 pulses, 2→1 after 8, reaches 0 with state_out=2 one cycle after the 12th.
- Single hit and flash, FLASH_FRAMES=4:
  - Stimulus: player_hit_in in PLAY.
  - Required: player_score=1, state 3; border_en toggles 1,0,1,0 over 4 frames; then state 1, countdown_out=3.
  - Also: opponent_hit_in during flash leaves opponent_score=0.
- Double touch to draw, WIN_SCORE=2:
  - Stimulus: from 1–1, simultaneous hits in PLAY.
  - Required: scores 2–2, state 4, winner_out=11, border_en=1.
- Reset mid-operation:
  - Stimulus: assert rst_n_in during HIT_FLASH with score 3–1.
  - Required: outputs clear immediately without a clock edge; state 0.
- Start-edge handling:
  - Stimulus: start_btn_in held high through reset release.
  - Required: no transition until a low→high edge.
  - Stimulus: start edge in ROUND_OVER.
  - Required: IDLE with scores retained; a second edge clears scores and enters COUNTDOWN.

Source files
------------

// File: rtl/fence_display_sequencer.sv
// Game-level sequencer for the fencing display: start screen, countdown, play, hit flash and
// round-over, driving the display mux layer selects and keeping score.
module fence_display_sequencer #(
    parameter int unsigned FRAMES_PER_SEC = 60,
    parameter int unsigned COUNTDOWN_SEC  = 3,
    parameter int unsigned FLASH_FRAMES   = 30,
    parameter int unsigned WIN_SCORE      = 5,
    parameter int unsigned SCORE_W        = 4
) (
    input  logic               clk_in,
    input  logic               rst_n_in,
    input  logic               new_frame_in,
    input  logic               start_btn_in,
    input  logic               player_hit_in,
    input  logic               opponent_hit_in,
    output logic               start_display_out,
    output logic               border_en_out,
    output logic               saber_en_out,
    output logic               box_en_out,
    output logic [3:0]         countdown_out,
    output logic [SCORE_W-1:0] player_score_out,
    output logic [SCORE_W-1:0] opponent_score_out,
    output logic [1:0]         winner_out,
    output logic [2:0]         state_out
);

    localparam int unsigned CntMax = (FRAMES_PER_SEC > FLASH_FRAMES) ? FRAMES_PER_SEC
                                                                      : FLASH_FRAMES;
    localparam int unsigned CntW   = $clog2(CntMax + 1);

    localparam logic [SCORE_W-1:0] ScoreMax = {SCORE_W{1'b1}};
    localparam logic [SCORE_W-1:0] ScoreWin = SCORE_W'(WIN_SCORE);
    localparam logic [3:0]         CdLoad   = 4'(COUNTDOWN_SEC);
    localparam logic [CntW-1:0]    SecLast  = CntW'(FRAMES_PER_SEC - 1);
    localparam logic [CntW-1:0]    FlashLast = CntW'(FLASH_FRAMES - 1);

    typedef enum logic [2:0] {
        StIdle      = 3'd0,
        StCountdown = 3'd1,
        StPlay      = 3'd2,
        StHitFlash  = 3'd3,
        StRoundOver = 3'd4
    } state_e;

    state_e             state_q, state_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [3:0]         countdown_q, countdown_d;
    logic [SCORE_W-1:0] player_score_q, player_score_d;
    logic [SCORE_W-1:0] opponent_score_q, opponent_score_d;
    logic [1:0]         winner_q, winner_d;
    logic               start_prev_q;
    logic               start_display_q, start_display_d;
    logic               border_q, border_d;
    logic               saber_q, saber_d;
    logic               box_q, box_d;

    logic               start_edge;
    logic               any_hit;
    logic [SCORE_W-1:0] player_upd, opponent_upd;
    logic               player_wins, opponent_wins;

    assign start_edge = start_btn_in & ~start_prev_q;
    assign any_hit    = player_hit_in | opponent_hit_in;

    // Saturating score updates and win detection on the post-hit scores.
    always_comb begin
        player_upd   = player_score_q;
        opponent_upd = opponent_score_q;
        if (player_hit_in && (player_score_q != ScoreMax)) begin
            player_upd = player_score_q + SCORE_W'(1);
        end
        if (opponent_hit_in && (opponent_score_q != ScoreMax)) begin
            opponent_upd = opponent_score_q + SCORE_W'(1);
        end
        player_wins   = (player_upd >= ScoreWin);
        opponent_wins = (opponent_upd >= ScoreWin);
    end

    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        countdown_d      = countdown_q;
        player_score_d   = player_score_q;
        opponent_score_d = opponent_score_q;
        winner_d         = winner_q;

        case (state_q)
            StIdle: begin
                if (start_edge) begin
                    player_score_d   = '0;
                    opponent_score_d = '0;
                    winner_d         = 2'b00;
                    countdown_d      = CdLoad;
                    cnt_d            = '0;
                    state_d          = StCountdown;
                end
            end
            StCountdown: begin
                if (new_frame_in) begin
                    if (cnt_q == SecLast) begin
                        cnt_d       = '0;
                        countdown_d = countdown_q - 4'd1;
                        if (countdown_q == 4'd1) begin
                            state_d = StPlay;
                        end
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
            end
            StPlay: begin
                if (any_hit) begin
                    player_score_d   = player_upd;
                    opponent_score_d = opponent_upd;
                    if (player_wins || opponent_wins) begin
                        winner_d = {opponent_wins, player_wins};
                        state_d  = StRoundOver;
                    end else begin
                        cnt_d   = '0;
                        state_d = StHitFlash;
                    end
                end
            end
            StHitFlash: begin
                if (new_frame_in) begin
                    if (cnt_q == FlashLast) begin
                        cnt_d       = '0;
                        countdown_d = CdLoad;
                        state_d     = StCountdown;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
            end
            StRoundOver: begin
                if (start_edge) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Layer selects are decoded from the next state so they register alongside it.
        start_display_d = (state_d == StIdle);
        box_d           = (state_d != StIdle);
        saber_d         = (state_d == StPlay);
        border_d        = (state_d == StRoundOver) || ((state_d == StHitFlash) && !cnt_d[0]);
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q          <= StIdle;
            cnt_q            <= '0;
            countdown_q      <= 4'd0;
            player_score_q   <= '0;
            opponent_score_q <= '0;
            winner_q         <= 2'b00;
            start_prev_q     <= 1'b1;
            start_display_q  <= 1'b1;
            border_q         <= 1'b0;
            saber_q          <= 1'b0;
            box_q            <= 1'b0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            countdown_q      <= countdown_d;
            player_score_q   <= player_score_d;
            opponent_score_q <= opponent_score_d;
            winner_q         <= winner_d;
            start_prev_q     <= start_btn_in;
            start_display_q  <= start_display_d;
            border_q         <= border_d;
            saber_q          <= saber_d;
            box_q            <= box_d;
        end
    end

    assign start_display_out  = start_display_q;
    assign border_en_out      = border_q;
    assign saber_en_out       = saber_q;
    assign box_en_out         = box_q;
    assign countdown_out      = countdown_q;
    assign player_score_out   = player_score_q;
    assign opponent_score_out = opponent_score_q;
    assign winner_out         = winner_q;
    assign state_out          = state_q;

endmodule

// File: tb/tb_fence_display_sequencer.sv
// Bench for fence_display_sequencer: two instances (win score 2 and 4) share stimulus and are
// compared every cycle against a frame-counting game model, plus directed literal checks.
module tb_fence_display_sequencer;

    localparam int F = 4;
    localparam int C = 3;
    localparam int L = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic nf = 1'b0;
    logic btn = 1'b0;
    logic ph = 1'b0;
    logic oh = 1'b0;

    logic       sd_w  [2];
    logic       bd_w  [2];
    logic       sb_w  [2];
    logic       bx_w  [2];
    logic [3:0] cd_w  [2];
    logic [3:0] ps_w  [2];
    logic [3:0] os_w  [2];
    logic [1:0] win_w [2];
    logic [2:0] st_w  [2];

    always #5 clk = ~clk;

    fence_display_sequencer #(
        .FRAMES_PER_SEC(F), .COUNTDOWN_SEC(C), .FLASH_FRAMES(L), .WIN_SCORE(2), .SCORE_W(4)
    ) u_dut_a (
        .clk_in(clk), .rst_n_in(rst_n), .new_frame_in(nf), .start_btn_in(btn),
        .player_hit_in(ph), .opponent_hit_in(oh),
        .start_display_out(sd_w[0]), .border_en_out(bd_w[0]), .saber_en_out(sb_w[0]),
        .box_en_out(bx_w[0]), .countdown_out(cd_w[0]), .player_score_out(ps_w[0]),
        .opponent_score_out(os_w[0]), .winner_out(win_w[0]), .state_out(st_w[0])
    );

    fence_display_sequencer #(
        .FRAMES_PER_SEC(F), .COUNTDOWN_SEC(C), .FLASH_FRAMES(L), .WIN_SCORE(4), .SCORE_W(4)
    ) u_dut_b (
        .clk_in(clk), .rst_n_in(rst_n), .new_frame_in(nf), .start_btn_in(btn),
        .player_hit_in(ph), .opponent_hit_in(oh),
        .start_display_out(sd_w[1]), .border_en_out(bd_w[1]), .saber_en_out(sb_w[1]),
        .box_en_out(bx_w[1]), .countdown_out(cd_w[1]), .player_score_out(ps_w[1]),
        .opponent_score_out(os_w[1]), .winner_out(win_w[1]), .state_out(st_w[1])
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int inst, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s[%0d] got %0d expected %0d at %0t", name, inst, act, exp, $time);
        end
    endtask

    // Model: state plus frames elapsed since entering COUNTDOWN or HIT_FLASH.
    int   m_state  [2];
    int   m_frames [2];
    int   m_ps     [2];
    int   m_os     [2];
    int   m_win    [2];
    logic m_prev = 1'b1;

    function automatic int win_of(input int i);
        return (i == 0) ? 2 : 4;
    endfunction

    function automatic int sat(input int v);
        return (v > 15) ? 15 : v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_state[i] = 0; m_frames[i] = 0; m_ps[i] = 0; m_os[i] = 0; m_win[i] = 0;
        end
        m_prev = 1'b1;
    endtask

    task automatic model_step();
        bit edge_seen;
        edge_seen = btn && !m_prev;
        m_prev = btn;
        for (int i = 0; i < 2; i++) begin
            case (m_state[i])
                0: if (edge_seen) begin
                    m_ps[i] = 0; m_os[i] = 0; m_win[i] = 0; m_frames[i] = 0; m_state[i] = 1;
                end
                1: if (nf) begin
                    m_frames[i]++;
                    if (m_frames[i] == C * F) m_state[i] = 2;
                end
                2: if (ph || oh) begin
                    m_ps[i] = sat(m_ps[i] + int'(ph));
                    m_os[i] = sat(m_os[i] + int'(oh));
                    if (m_ps[i] >= win_of(i) || m_os[i] >= win_of(i)) begin
                        m_win[i] = (m_os[i] >= win_of(i) ? 2 : 0) + (m_ps[i] >= win_of(i) ? 1 : 0);
                        m_state[i] = 4;
                    end else begin
                        m_frames[i] = 0;
                        m_state[i] = 3;
                    end
                end
                3: if (nf) begin
                    m_frames[i]++;
                    if (m_frames[i] == L) begin
                        m_frames[i] = 0;
                        m_state[i] = 1;
                    end
                end
                default: if (edge_seen) m_state[i] = 0;
            endcase
        end
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) model_reset();
        else model_step();
    end

    initial forever begin
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            int s;
            s = m_state[i];
            chk("state", i, int'(st_w[i]), s);
            chk("start_display", i, int'(sd_w[i]), (s == 0) ? 1 : 0);
            chk("box_en", i, int'(bx_w[i]), (s != 0) ? 1 : 0);
            chk("saber_en", i, int'(sb_w[i]), (s == 2) ? 1 : 0);
            chk("border_en", i, int'(bd_w[i]),
                (s == 4 || (s == 3 && (m_frames[i] % 2) == 0)) ? 1 : 0);
            chk("countdown", i, int'(cd_w[i]), (s == 1) ? (C - m_frames[i] / F) : 0);
            chk("player_score", i, int'(ps_w[i]), m_ps[i]);
            chk("opponent_score", i, int'(os_w[i]), m_os[i]);
            chk("winner", i, int'(win_w[i]), m_win[i]);
        end
    end

    task automatic drive(input logic f, input logic p, input logic o, input logic b);
        nf = f; ph = p; oh = o; btn = b;
        @(posedge clk);
        #2;
    endtask

    task automatic frames(input int n);
        repeat (n) drive(1'b1, 1'b0, 1'b0, btn);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 1'b0, btn);
    endtask

    task automatic press();
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        // Button held high through reset release: no edge.
        btn = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        idle(5);
        chk("lit_hold_state", 0, int'(st_w[0]), 0);
        chk("lit_hold_sd", 0, int'(sd_w[0]), 1);
        chk("lit_hold_ps", 0, int'(ps_w[0]), 0);
        chk("lit_hold_win", 0, int'(win_w[0]), 0);

        press();
        chk("lit_cd_state", 0, int'(st_w[0]), 1);
        chk("lit_cd_load", 0, int'(cd_w[0]), 3);
        frames(4);
        chk("lit_cd_after4", 0, int'(cd_w[0]), 2);
        frames(4);
        chk("lit_cd_after8", 0, int'(cd_w[0]), 1);
        frames(3);
        chk("lit_cd_after11", 0, int'(st_w[0]), 1);
        frames(1);
        chk("lit_play_state", 0, int'(st_w[0]), 2);
        chk("lit_play_cd", 0, int'(cd_w[0]), 0);
        chk("lit_play_saber", 0, int'(sb_w[0]), 1);

        drive(1'b0, 1'b1, 1'b0, btn);
        chk("lit_hit_ps", 0, int'(ps_w[0]), 1);
        chk("lit_hit_state", 0, int'(st_w[0]), 3);
        chk("lit_flash0", 0, int'(bd_w[0]), 1);
        drive(1'b0, 1'b0, 1'b1, btn);
        chk("lit_flash_ignore_os", 0, int'(os_w[0]), 0);
        frames(1);
        chk("lit_flash1", 0, int'(bd_w[0]), 0);
        frames(1);
        chk("lit_flash2", 0, int'(bd_w[0]), 1);
        frames(1);
        chk("lit_flash3", 0, int'(bd_w[0]), 0);
        frames(1);
        chk("lit_reload_state", 0, int'(st_w[0]), 1);
        chk("lit_reload_cd", 0, int'(cd_w[0]), 3);

        // To 1-1, then a double touch.
        frames(12);
        drive(1'b0, 1'b0, 1'b1, btn);
        frames(4);
        frames(12);
        drive(1'b0, 1'b1, 1'b1, btn);
        chk("lit_draw_ps", 0, int'(ps_w[0]), 2);
        chk("lit_draw_os", 0, int'(os_w[0]), 2);
        chk("lit_draw_state", 0, int'(st_w[0]), 4);
        chk("lit_draw_winner", 0, int'(win_w[0]), 3);
        chk("lit_draw_border", 0, int'(bd_w[0]), 1);
        chk("lit_nodraw_state", 1, int'(st_w[1]), 3);

        press();
        chk("lit_ro_idle", 0, int'(st_w[0]), 0);
        chk("lit_ro_keep_ps", 0, int'(ps_w[0]), 2);
        chk("lit_ro_keep_win", 0, int'(win_w[0]), 3);
        press();
        chk("lit_restart_state", 0, int'(st_w[0]), 1);
        chk("lit_restart_ps", 0, int'(ps_w[0]), 0);
        chk("lit_restart_win", 0, int'(win_w[0]), 0);
        chk("lit_flash_ignores_btn", 1, int'(st_w[1]), 3);

        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        idle(1);
        press();
        for (int k = 0; k < 4; k++) begin
            frames(12);
            if (k == 2) drive(1'b0, 1'b0, 1'b1, btn);
            else drive(1'b0, 1'b1, 1'b0, btn);
            if (k != 3) frames(4);
        end
        chk("lit_31_ps", 1, int'(ps_w[1]), 3);
        chk("lit_31_os", 1, int'(os_w[1]), 1);
        chk("lit_31_state", 1, int'(st_w[1]), 3);

        // Asynchronous reset between clock edges.
        #1;
        rst_n = 1'b0;
        #1;
        chk("lit_async_state", 1, int'(st_w[1]), 0);
        chk("lit_async_ps", 1, int'(ps_w[1]), 0);
        chk("lit_async_os", 1, int'(os_w[1]), 0);
        chk("lit_async_sd", 1, int'(sd_w[1]), 1);
        chk("lit_async_box", 1, int'(bx_w[1]), 0);
        chk("lit_async_border", 1, int'(bd_w[1]), 0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        for (int n = 0; n < 4000; n++) begin
            rst_n = ($urandom_range(0, 399) != 0);
            drive($urandom_range(0, 1) == 1, $urandom_range(0, 5) == 0,
                  $urandom_range(0, 5) == 0,
                  ($urandom_range(0, 9) == 0) ? ~btn : btn);
        end
        rst_n = 1'b1;
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
